// File: rtl/timer_driver_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : timer_driver_master_if
//  Description : Bundles the start-timer command handshake and the Avalon-MM
//                timer-slave bus (including the slave's irq line) seen by
//                timer_driver_master.
//                master modport : the driver's view (drives bus, takes cmds)
//                slave  modport : the opposite side (command source + slave)
//  Signals     : cmd_valid/cmd_ready/cmd_period/cmd_continuous - command
//                address/chipselect/write_n/writedata/readdata   - slave bus
//                irq                                             - timer irq
//  Revision    : 1.0  initial release
// ============================================================================
interface timer_driver_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_period;
    logic        cmd_continuous;
    logic        irq;
    logic [15:0] readdata;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;

    modport master (
        input  cmd_valid, cmd_period, cmd_continuous, irq, readdata,
        output cmd_ready, address, chipselect, write_n, writedata
    );

    modport slave (
        output cmd_valid, cmd_period, cmd_continuous, irq, readdata,
        input  cmd_ready, address, chipselect, write_n, writedata
    );
endinterface
`default_nettype wire

// File: rtl/timer_driver_master.sv
`default_nettype none
// ============================================================================
//  Module      : timer_driver_master
//  Description : Programs an interval-timer slave over a 16-bit Avalon-MM bus
//                (period low/high, control), services its expiry interrupt
//                (status clear + tick count), stops it on request and takes
//                32-bit counter snapshots on request.
//  Ports       : clk, reset_n (synchronous, active-low)
//                bus        - command handshake + timer slave bus (master mp)
//                stop_req   - pulse, stop a running timer
//                snap_req   - pulse, capture the slave's counter snapshot
//                busy       - high whenever not IDLE
//                tick_count - serviced expiries, wraps at 2^TICK_W
//                tick_pulse - one clock per serviced expiry
//                snap_value - last snapshot, snap_valid pulses on update
//  Revision    : 1.0  initial release
// ============================================================================
module timer_driver_master #(
    parameter int TICK_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    timer_driver_master_if.master bus,
    input  logic                  stop_req,
    input  logic                  snap_req,
    output logic                  busy,
    output logic [TICK_W-1:0]     tick_count,
    output logic                  tick_pulse,
    output logic [31:0]           snap_value,
    output logic                  snap_valid
);

    localparam logic [3:0] c_ST_IDLE     = 4'd0;
    localparam logic [3:0] c_ST_WR_PL    = 4'd1;
    localparam logic [3:0] c_ST_WR_PH    = 4'd2;
    localparam logic [3:0] c_ST_WR_CTRL  = 4'd3;
    localparam logic [3:0] c_ST_WAIT_IRQ = 4'd4;
    localparam logic [3:0] c_ST_CLR_STAT = 4'd5;
    localparam logic [3:0] c_ST_SNAP_WR  = 4'd6;
    localparam logic [3:0] c_ST_RD_L     = 4'd7;
    localparam logic [3:0] c_ST_CAP_L    = 4'd8;
    localparam logic [3:0] c_ST_CAP_H    = 4'd9;
    localparam logic [3:0] c_ST_STOP_WR  = 4'd10;

    localparam logic [2:0] c_A_STATUS = 3'd0;
    localparam logic [2:0] c_A_CTRL   = 3'd1;
    localparam logic [2:0] c_A_PER_L  = 3'd2;
    localparam logic [2:0] c_A_PER_H  = 3'd3;
    localparam logic [2:0] c_A_SNAP_L = 3'd4;
    localparam logic [2:0] c_A_SNAP_H = 3'd5;

    // Control words: ITO=bit0, CONT=bit1, START=bit2, STOP=bit3
    localparam logic [15:0] c_CTRL_ONESHOT = 16'h0005;
    localparam logic [15:0] c_CTRL_CONT    = 16'h0007;
    localparam logic [15:0] c_CTRL_STOP    = 16'h0008;

    logic [3:0]        r_state;
    logic [3:0]        w_state_next;

    logic              r_cont;
    logic [15:0]       r_period_hi;
    logic              r_stop_pend;
    logic              r_snap_pend;
    logic [15:0]       r_snap_lo;

    logic              r_chipselect;
    logic              r_write_n;
    logic [2:0]        r_address;
    logic [15:0]       r_writedata;
    logic [TICK_W-1:0] r_tick_count;
    logic              r_tick_pulse;
    logic [31:0]       r_snap_value;
    logic              r_snap_valid;

    logic              w_accept;
    logic              w_stop_any;
    logic              w_snap_any;

    logic              w_cs_d;
    logic              w_wn_d;
    logic [2:0]        w_addr_d;
    logic [15:0]       w_wd_d;
    logic              w_tick_d;

    assign w_accept   = (r_state == c_ST_IDLE) && bus.cmd_valid;
    // A request seen this cycle counts the same as one latched earlier.
    assign w_stop_any = stop_req | r_stop_pend;
    assign w_snap_any = snap_req | r_snap_pend;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:     if (w_accept) w_state_next = c_ST_WR_PL;
            c_ST_WR_PL:    w_state_next = c_ST_WR_PH;
            c_ST_WR_PH:    w_state_next = c_ST_WR_CTRL;
            c_ST_WR_CTRL:  w_state_next = c_ST_WAIT_IRQ;
            c_ST_WAIT_IRQ: begin
                if (bus.irq)         w_state_next = c_ST_CLR_STAT;
                else if (w_stop_any) w_state_next = c_ST_STOP_WR;
                else if (w_snap_any) w_state_next = c_ST_SNAP_WR;
            end
            c_ST_CLR_STAT: begin
                // Only a stop latched before this cycle diverts here; a stop
                // arriving now is picked up back in WAIT_IRQ.
                if (r_stop_pend)  w_state_next = c_ST_STOP_WR;
                else if (r_cont)  w_state_next = c_ST_WAIT_IRQ;
                else              w_state_next = c_ST_IDLE;
            end
            c_ST_SNAP_WR:  w_state_next = c_ST_RD_L;
            c_ST_RD_L:     w_state_next = c_ST_CAP_L;
            c_ST_CAP_L:    w_state_next = c_ST_CAP_H;
            c_ST_CAP_H:    w_state_next = c_ST_WAIT_IRQ;
            c_ST_STOP_WR:  w_state_next = c_ST_IDLE;
            default:       w_state_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from the next state, so the registered bus outputs
    // line up with the state that owns them.
    // ------------------------------------------------------------------
    always_comb begin
        w_cs_d   = 1'b0;
        w_wn_d   = 1'b1;
        w_addr_d = r_address;
        w_wd_d   = r_writedata;
        w_tick_d = 1'b0;
        case (w_state_next)
            c_ST_WR_PL: begin
                // Only reachable on accept, so the low half comes straight
                // from the command port.
                w_cs_d = 1'b1; w_wn_d = 1'b0;
                w_addr_d = c_A_PER_L; w_wd_d = bus.cmd_period[15:0];
            end
            c_ST_WR_PH: begin
                w_cs_d = 1'b1; w_wn_d = 1'b0;
                w_addr_d = c_A_PER_H; w_wd_d = r_period_hi;
            end
            c_ST_WR_CTRL: begin
                w_cs_d = 1'b1; w_wn_d = 1'b0;
                w_addr_d = c_A_CTRL;
                w_wd_d = r_cont ? c_CTRL_CONT : c_CTRL_ONESHOT;
            end
            c_ST_CLR_STAT: begin
                w_cs_d = 1'b1; w_wn_d = 1'b0;
                w_addr_d = c_A_STATUS; w_wd_d = 16'h0000;
                w_tick_d = 1'b1;
            end
            c_ST_SNAP_WR: begin
                w_cs_d = 1'b1; w_wn_d = 1'b0;
                w_addr_d = c_A_SNAP_L; w_wd_d = 16'h0000;
            end
            c_ST_RD_L: begin
                w_cs_d = 1'b1; w_addr_d = c_A_SNAP_L;
            end
            c_ST_CAP_L: begin
                w_cs_d = 1'b1; w_addr_d = c_A_SNAP_H;
            end
            c_ST_STOP_WR: begin
                w_cs_d = 1'b1; w_wn_d = 1'b0;
                w_addr_d = c_A_CTRL; w_wd_d = c_CTRL_STOP;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_chipselect <= 1'b0;
            r_write_n    <= 1'b1;
            r_address    <= 3'd0;
            r_writedata  <= 16'h0000;
            r_tick_count <= '0;
            r_tick_pulse <= 1'b0;
            r_snap_value <= 32'h0000_0000;
            r_snap_valid <= 1'b0;
            r_snap_lo    <= 16'h0000;
            r_cont       <= 1'b0;
            r_period_hi  <= 16'h0000;
        end else begin
            r_chipselect <= w_cs_d;
            r_write_n    <= w_wn_d;
            r_address    <= w_addr_d;
            r_writedata  <= w_wd_d;
            r_tick_pulse <= w_tick_d;
            if (w_tick_d) begin
                r_tick_count <= r_tick_count + TICK_W'(1);
            end
            if (w_accept) begin
                r_cont      <= bus.cmd_continuous;
                r_period_hi <= bus.cmd_period[31:16];
            end
            if (r_state == c_ST_CAP_L) begin
                r_snap_lo <= bus.readdata;
            end
            r_snap_valid <= (r_state == c_ST_CAP_H);
            if (r_state == c_ST_CAP_H) begin
                r_snap_value <= {bus.readdata, r_snap_lo};
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending stop/snap requests. Requests are latched while the driver
    // is occupied with a status clear or snapshot, consumed when WAIT_IRQ
    // acts on them, and dropped whenever the driver returns to IDLE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_stop_pend <= 1'b0;
            r_snap_pend <= 1'b0;
        end else if (w_state_next == c_ST_IDLE) begin
            r_stop_pend <= 1'b0;
            r_snap_pend <= 1'b0;
        end else begin
            case (r_state)
                c_ST_WAIT_IRQ: begin
                    if (bus.irq) begin
                        r_stop_pend <= w_stop_any;
                        r_snap_pend <= w_snap_any;
                    end else if (w_stop_any) begin
                        r_stop_pend <= 1'b0;
                        r_snap_pend <= w_snap_any;
                    end else if (w_snap_any) begin
                        r_snap_pend <= 1'b0;
                    end
                end
                c_ST_CLR_STAT, c_ST_SNAP_WR, c_ST_RD_L,
                c_ST_CAP_L, c_ST_CAP_H: begin
                    r_stop_pend <= w_stop_any;
                    r_snap_pend <= w_snap_any;
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready  = (r_state == c_ST_IDLE);
    assign bus.chipselect = r_chipselect;
    assign bus.write_n    = r_write_n;
    assign bus.address    = r_address;
    assign bus.writedata  = r_writedata;
    assign busy           = (r_state != c_ST_IDLE);
    assign tick_count     = r_tick_count;
    assign tick_pulse     = r_tick_pulse;
    assign snap_value     = r_snap_value;
    assign snap_valid     = r_snap_valid;

endmodule
`default_nettype wire

// File: tb/tb_timer_driver_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_driver_master
//  Description : Self-checking bench for timer_driver_master (TICK_W=4).
//                A registered timer-slave model logs writes, answers snapshot
//                reads and raises/clears irq; a transaction-level model
//                predicts the write stream, tick count and snapshots.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_timer_driver_master;

    localparam int TW = 4;

    localparam int E_IRQ          = 0;
    localparam int E_STOP         = 1;
    localparam int E_SNAP         = 2;
    localparam int E_IRQ_STOP     = 3;
    localparam int E_IRQ_SNAP     = 4;
    localparam int E_SNAP_IRQ     = 5;
    localparam int E_SNAP_STOP    = 6;
    localparam int E_STOP_SNAP    = 7;
    localparam int E_IRQ_STOPLATE = 8;
    localparam int E_CMD_BUSY     = 9;
    localparam int E_IDLE_REQ     = 10;

    logic          clk;
    logic          reset_n;
    logic          stop_req;
    logic          snap_req;
    logic          busy;
    logic [TW-1:0] tick_count;
    logic          tick_pulse;
    logic [31:0]   snap_value;
    logic          snap_valid;

    timer_driver_master_if bus ();

    timer_driver_master #(.TICK_W(TW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .stop_req   (stop_req),
        .snap_req   (snap_req),
        .busy       (busy),
        .tick_count (tick_count),
        .tick_pulse (tick_pulse),
        .snap_value (snap_value),
        .snap_valid (snap_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- timer slave model ----------------
    logic        irq_set;
    logic        irq_q;
    logic [15:0] rd_q;
    logic [31:0] snap_src;
    logic [31:0] snap_lat;
    logic [18:0] obs_q[$];
    logic [18:0] exp_q[$];

    assign bus.irq      = irq_q;
    assign bus.readdata = rd_q;

    always @(posedge clk) begin
        if (bus.chipselect && !bus.write_n) begin
            obs_q.push_back({bus.address, bus.writedata});
            if (bus.address == 3'd4) snap_lat <= snap_src;
        end
        if (bus.chipselect && bus.write_n) begin
            if (bus.address == 3'd4)      rd_q <= snap_lat[15:0];
            else if (bus.address == 3'd5) rd_q <= snap_lat[31:16];
            else                          rd_q <= 16'h0000;
        end
        if (!reset_n)     irq_q <= 1'b0;
        else if (irq_set) irq_q <= 1'b1;
        else if (bus.chipselect && !bus.write_n && bus.address == 3'd0) irq_q <= 1'b0;
    end

    int ntick_seen = 0;
    int nsnap_seen = 0;
    always @(negedge clk) begin
        if (tick_pulse === 1'b1) ntick_seen++;
        if (snap_valid === 1'b1) nsnap_seen++;
    end

    // ---------------- reference model state ----------------
    int          m_tick   = 0;
    int          m_ntick  = 0;
    int          m_nsnap  = 0;
    logic [31:0] m_snap   = 32'h0;
    bit          m_active = 1'b0;
    bit          m_cont   = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [20:0] bus_w();
        return {bus.chipselect, bus.write_n, bus.address, bus.writedata};
    endfunction

    function automatic logic [20:0] wr(input logic [2:0] a, input logic [15:0] d);
        return {1'b1, 1'b0, a, d};
    endfunction

    function automatic logic [20:0] idle_w(input logic [2:0] a, input logic [15:0] d);
        return {1'b0, 1'b1, a, d};
    endfunction

    function automatic void m_irq();
        exp_q.push_back({3'd0, 16'h0000});
        m_tick++;
        m_ntick++;
    endfunction

    function automatic void m_snapshot(input logic [31:0] v);
        exp_q.push_back({3'd4, 16'h0000});
        m_snap = v;
        m_nsnap++;
    endfunction

    function automatic void m_stop();
        exp_q.push_back({3'd1, 16'h0008});
        m_active = 1'b0;
    endfunction

    task automatic sync_check(input string tag);
        check({tag, "_nwr"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check({tag, "_wr"}, obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
        check({tag, "_tick"}, tick_count, m_tick % (1 << TW));
        check({tag, "_ntick"}, ntick_seen, m_ntick);
        check({tag, "_snapv"}, snap_value, m_snap);
        check({tag, "_nsnap"}, nsnap_seen, m_nsnap);
        check({tag, "_busy"}, busy, m_active);
    endtask

    // one cycle of request pulses, starting and ending at a negedge
    task automatic step(input bit i, input bit s, input bit n);
        irq_set = i; stop_req = s; snap_req = n;
        @(negedge clk);
        irq_set = 1'b0; stop_req = 1'b0; snap_req = 1'b0;
    endtask

    task automatic start_cmd(input logic [31:0] p, input bit c);
        check("cmd_ready_idle", bus.cmd_ready, 1'b1);
        bus.cmd_valid = 1'b1; bus.cmd_period = p; bus.cmd_continuous = c;
        @(negedge clk);
        bus.cmd_valid = 1'b0; bus.cmd_period = $urandom; bus.cmd_continuous = $urandom;
        check("cmd_ready_after", bus.cmd_ready, 1'b0);
        check("wr_per_l", bus_w(), wr(3'd2, p[15:0]));
        @(negedge clk);
        check("wr_per_h", bus_w(), wr(3'd3, p[31:16]));
        @(negedge clk);
        check("wr_ctrl", bus_w(), wr(3'd1, c ? 16'h0007 : 16'h0005));
        @(negedge clk);
        check("wait_hold", bus_w(), idle_w(3'd1, c ? 16'h0007 : 16'h0005));
        exp_q.push_back({3'd2, p[15:0]});
        exp_q.push_back({3'd3, p[31:16]});
        exp_q.push_back({3'd1, c ? 16'h0007 : 16'h0005});
        m_active = 1'b1;
        m_cont   = c;
    endtask

    task automatic drive_event(input int kind);
        logic [31:0] v;
        v = $urandom;
        snap_src = v;
        case (kind)
            E_IRQ:          step(1, 0, 0);
            E_STOP:         step(0, 1, 0);
            E_SNAP:         step(0, 0, 1);
            E_IRQ_STOP:     begin step(1, 0, 0); step(0, 1, 0); end
            E_IRQ_SNAP:     begin step(1, 0, 0); step(0, 0, 1); end
            E_SNAP_IRQ:     begin step(0, 0, 1); step(1, 0, 0); end
            E_SNAP_STOP:    begin step(0, 0, 1); step(0, 0, 0); step(0, 1, 0); end
            E_STOP_SNAP:    step(0, 1, 1);
            E_IRQ_STOPLATE: begin step(1, 0, 0); step(0, 0, 0); step(0, 1, 0); end
            E_CMD_BUSY: begin
                bus.cmd_valid = 1'b1; bus.cmd_period = $urandom; bus.cmd_continuous = $urandom;
                @(negedge clk);
                bus.cmd_valid = 1'b0;
            end
            E_IDLE_REQ:     step(0, 1, 1);
            default:        ;
        endcase
        repeat (14) @(negedge clk);
        case (kind)
            E_IRQ:       begin m_irq(); if (!m_cont) m_active = 1'b0; end
            E_STOP:      m_stop();
            E_SNAP:      m_snapshot(v);
            E_IRQ_STOP:  begin m_irq(); m_stop(); end
            E_IRQ_SNAP:  begin m_irq(); if (m_cont) m_snapshot(v); else m_active = 1'b0; end
            E_SNAP_IRQ:  begin m_snapshot(v); m_irq(); if (!m_cont) m_active = 1'b0; end
            E_SNAP_STOP: begin m_snapshot(v); m_stop(); end
            E_STOP_SNAP: m_stop();
            E_IRQ_STOPLATE: begin m_irq(); if (m_cont) m_stop(); else m_active = 1'b0; end
            default:     ;
        endcase
        sync_check($sformatf("ev%0d", kind));
    endtask

    initial begin
        logic [31:0] p;
        bit          c;
        reset_n = 1'b0; stop_req = 1'b0; snap_req = 1'b0; irq_set = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_period = 32'h0; bus.cmd_continuous = 1'b0;
        snap_src = 32'h0; snap_lat = 32'h0; rd_q = 16'h0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_bus", bus_w(), idle_w(3'd0, 16'h0000));
        check("rst_tick", tick_count, 0);
        check("rst_tpulse", tick_pulse, 1'b0);
        check("rst_snapv", snap_value, 32'h0);
        check("rst_snapvalid", snap_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", bus.cmd_ready, 1'b1);
        reset_n = 1'b1;
        @(negedge clk);

        // continuous command, then one irq service
        start_cmd(32'h0001D4BF, 1'b1);
        step(1, 0, 0);
        check("irq_wait_quiet", bus_w(), idle_w(3'd1, 16'h0007));
        @(negedge clk);
        check("clr_stat_wr", bus_w(), wr(3'd0, 16'h0000));
        check("clr_tpulse", tick_pulse, 1'b1);
        check("clr_tick", tick_count, 1);
        @(negedge clk);
        check("clr_after_bus", bus_w(), idle_w(3'd0, 16'h0000));
        check("clr_after_tpulse", tick_pulse, 1'b0);
        check("clr_after_busy", busy, 1'b1);
        m_irq();

        // snapshot timing and data
        snap_src = 32'hABCD1234;
        step(0, 0, 1);
        check("snap_wr", bus_w(), wr(3'd4, 16'h0000));
        @(negedge clk);
        check("snap_rd_l", bus_w(), {1'b1, 1'b1, 3'd4, 16'h0000});
        @(negedge clk);
        check("snap_rd_h", bus_w(), {1'b1, 1'b1, 3'd5, 16'h0000});
        @(negedge clk);
        check("snap_cap_h_bus", bus_w(), idle_w(3'd5, 16'h0000));
        check("snap_early", snap_valid, 1'b0);
        @(negedge clk);
        check("snap_valid", snap_valid, 1'b1);
        check("snap_value", snap_value, 32'hABCD1234);
        @(negedge clk);
        check("snap_valid_end", snap_valid, 1'b0);
        m_snapshot(32'hABCD1234);

        // irq and stop in the same clock
        step(1, 0, 0);
        step(0, 1, 0);
        check("is_clr", bus_w(), wr(3'd0, 16'h0000));
        @(negedge clk);
        check("is_stop", bus_w(), wr(3'd1, 16'h0008));
        @(negedge clk);
        check("is_idle_bus", bus_w(), idle_w(3'd1, 16'h0008));
        check("is_ready", bus.cmd_ready, 1'b1);
        m_irq();
        m_stop();
        repeat (2) @(negedge clk);
        sync_check("dir1");

        // one-shot expiry returns to IDLE; requests while idle are ignored
        start_cmd($urandom, 1'b0);
        drive_event(E_IRQ);
        check("oneshot_ready", bus.cmd_ready, 1'b1);
        drive_event(E_IDLE_REQ);

        // reset during WR_PH aborts the sequence
        p = $urandom;
        bus.cmd_valid = 1'b1; bus.cmd_period = p; bus.cmd_continuous = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("ab_wr_pl", bus_w(), wr(3'd2, p[15:0]));
        @(negedge clk);
        check("ab_wr_ph", bus_w(), wr(3'd3, p[31:16]));
        reset_n = 1'b0;
        @(negedge clk);
        check("ab_bus", bus_w(), idle_w(3'd0, 16'h0000));
        check("ab_tick", tick_count, 0);
        check("ab_ready", bus.cmd_ready, 1'b1);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        exp_q.push_back({3'd2, p[15:0]});
        exp_q.push_back({3'd3, p[31:16]});
        m_tick = 0; m_snap = 32'h0; m_active = 1'b0;
        sync_check("abort");

        // tick counter wraps after 2^TW expiries
        start_cmd($urandom, 1'b1);
        for (int i = 0; i < (1 << TW); i++) drive_event(E_IRQ);
        check("tick_wrap", tick_count, 0);
        drive_event(E_STOP);

        // randomized commands and request mixes
        for (int n = 0; n < 25; n++) begin
            p = $urandom;
            c = 1'($urandom_range(0, 1));
            start_cmd(p, c);
            for (int k = 0; k < 6 && m_active; k++)
                drive_event($urandom_range(0, 9));
            if (m_active) drive_event(E_STOP);
            if ($urandom_range(0, 3) == 0) drive_event(E_IDLE_REQ);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/timer_driver_master.md
TIMER_DRIVER_MASTER -- requirements
Module: timer_driver_master

Interface
REQ-001 Parameter TICK_W, default 16: width of the timer-expiry counter output.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 reset_n  in  1  reset, synchronous, active-low.
REQ-004 cmd_valid  in  1  start-timer command request.
REQ-005 cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid && cmd_ready.
REQ-006 cmd_period  in  32  raw period register value; timer expires every cmd_period+1 clocks.
REQ-007 cmd_continuous  in  1  1 = periodic, 0 = one-shot.
REQ-008 stop_req  in  1  single-cycle pulse; stops a running timer.
REQ-009 snap_req  in  1  single-cycle pulse; requests a 32-bit counter snapshot.
REQ-010 irq  in  1  timer interrupt, level, held until status is cleared.
REQ-011 readdata  in  16  timer slave read data; registered, valid one clock after address is presented.
REQ-012 address  out  3  timer slave word address (0 status, 1 control, 2 period_l, 3 period_h, 4 snap_l, 5 snap_h).
REQ-013 chipselect  out  1  slave select.
REQ-014 write_n  out  1  active-low write strobe.
REQ-015 writedata  out  16  slave write data.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 tick_count  out  TICK_W  number of serviced expiries.
REQ-018 tick_pulse  out  1  one-clock pulse per serviced expiry.
REQ-019 snap_value  out  32  last captured snapshot; snap_valid  out  1  one-clock pulse on update.

Function
REQ-020 All Avalon outputs SHALL be registered; the slave has no waitrequest, so each write completes in one clock with chipselect=1, write_n=0.
REQ-021 In idle cycles chipselect=0, write_n=1, address and writedata SHALL hold their last values.
REQ-022 States: IDLE, WR_PL, WR_PH, WR_CTRL, WAIT_IRQ, CLR_STAT, SNAP_WR, RD_L, CAP_L, CAP_H, STOP_WR.
REQ-023 IDLE -> WR_PL on command accept; cmd_period and cmd_continuous SHALL be latched at accept.
REQ-024 WR_PL writes address 2 = period[15:0]; WR_PH writes address 3 = period[31:16]; WR_CTRL writes address 1 = 0x0005 (one-shot) or 0x0007 (continuous), i.e. ITO=1, CONT, START=1, STOP=0; then WAIT_IRQ.
REQ-025 In WAIT_IRQ priority is irq > stop > snap; lower-priority requests arriving together SHALL be latched as pending, not lost.
REQ-026 CLR_STAT writes address 0 = 0x0000, pulses tick_pulse, increments tick_count modulo 2^TICK_W; next state STOP_WR if stop pending, else WAIT_IRQ if continuous, else IDLE.
REQ-027 Returning from CLR_STAT to IDLE (one-shot) SHALL clear pending stop and snap flags.
REQ-028 STOP_WR writes address 1 = 0x0008 (STOP=1, ITO=0); then IDLE; pending stop cleared.
REQ-029 Snapshot: SNAP_WR writes address 4 (data 0x0000); RD_L drives address 4, chipselect=1, write_n=1; CAP_L captures readdata as snap[15:0] and drives address 5; CAP_H captures readdata as snap[31:16], updates snap_value, pulses snap_valid; then WAIT_IRQ.
REQ-030 irq or stop_req arriving during a snapshot or CLR_STAT SHALL be latched and serviced on return to WAIT_IRQ (irq level is re-sampled there).
REQ-031 stop_req or snap_req while IDLE or during WR_PL..WR_CTRL SHALL be ignored.
REQ-032 cmd_valid while busy SHALL be ignored (cmd_ready=0).

Reset
REQ-033 reset_n=0 at a rising edge SHALL, regardless of state: state=IDLE, chipselect=0, write_n=1, address=0, writedata=0, tick_count=0, tick_pulse=0, snap_value=0, snap_valid=0, pending flags=0; consequently busy=0, cmd_ready=1.
REQ-034 Reset mid-sequence SHALL abort without completing the sequence's remaining writes.

Verification
REQ-035 After reset, cmd_valid with period 0x0001D4BF, continuous=1 -> consecutive writes addr2=0xD4BF, addr3=0x0001, addr1=0x0007; cmd_ready=0 from the cycle after accept.
REQ-036 irq=1 in WAIT_IRQ -> next clock write addr0=0x0000, tick_pulse one clock, tick_count 0->1, back to WAIT_IRQ; one-shot instead -> IDLE, cmd_ready=1.
REQ-037 snap_req with slave model returning 0x1234 at addr4, 0xABCD at addr5 -> snap_value=0xABCD1234, snap_valid for one clock, 4 clocks after request.
REQ-038 irq and stop_req in same clock -> addr0 write, then addr1=0x0008, then IDLE; tick_count incremented once.
REQ-039 TICK_W=4, 16 serviced expiries -> tick_count wraps to 0.
REQ-040 reset_n low during WR_PH -> next clock chipselect=0, write_n=1, tick_count=0, cmd_ready=1; no addr1 write occurs.
